// File: rtl/muldiv_pkg.sv
// Shared encodings for the muldiv_hilo multiply/divide unit: opcodes, FSM states, constants.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Quotient returned for any divide by zero; truncated to WIDTH at the use site.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  function automatic logic op_is_div(input logic [1:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] b,
  input  logic             mq_lsb,
  input  logic             mq_msb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           borrow;

  // q_bit is the bit shifted into the mq register: a product bit leaving the
  // accumulator on multiply, a quotient bit on divide.
  always_comb begin
    // NOTE: every output and temporary is assigned on every path, so no latch is inferred.
    sum     = {1'b0, acc} + {1'b0, (mq_lsb ? b : '0)};
    shifted = {acc, mq_msb};
    borrow  = shifted < {1'b0, b};
    acc_nxt = sum[WIDTH:1];
    q_bit   = sum[0];
    if (div_mode) begin
      q_bit   = ~borrow;
      // The partial remainder stays below the divisor, so WIDTH bits always suffice.
      acc_nxt = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - b);
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO register pair.
// Define MULDIV_FAST_MULT_EN for single-pass multiplies; DIV/DIVU always iterate.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW        = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               neg_q;
  logic               neg_r;
  logic               div0_q;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;

  logic               div_in;
  logic               div_run;
  logic               signed_in;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   acc_nxt;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != ST_IDLE);

  // Operands are iterated as magnitudes; signs are restored in FIX.
  always_comb begin
    div_in    = op_is_div(op);
    div_run   = op_is_div(op_q);
    signed_in = op_is_signed(op);
    rs_mag    = (signed_in && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_mag    = (signed_in && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    prod      = {acc, mq};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = div0_q ? WIDTH'(DIV0_QUOTIENT) : (neg_q ? -mq : mq);
    rem_fix   = neg_r ? -acc : acc;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_run),
    .acc      (acc),
    .b        (d_q),
    .mq_lsb   (mq[0]),
    .mq_msb   (mq[WIDTH-1]),
    .acc_nxt  (acc_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= OP_MULT;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_q <= 1'b0;
      d_q    <= '0;
      acc    <= '0;
      mq     <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            neg_q  <= signed_in & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r  <= signed_in & rs_data[WIDTH-1];
            div0_q <= div_in && (rt_data == '0);
            cnt    <= '0;
            acc    <= '0;
            d_q    <= div_in ? rt_mag : rs_mag;
            mq     <= div_in ? rs_mag : rt_mag;
            state  <= ST_CALC;
`ifdef MULDIV_FAST_MULT_EN
            if (!div_in) begin
              {acc, mq} <= rs_mag * rt_mag;
              state     <= ST_FIX;
            end
`endif
          end else begin
            // Moves to HI/LO lose to a simultaneous start.
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          mq  <= div_run ? {mq[WIDTH-2:0], q_bit} : {q_bit, mq[WIDTH-1:1]};
          if (cnt == LAST_ITER) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (div_run) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          cnt   <= '0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed vectors plus random ops against an arithmetic model.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_hilo #(.WIDTH(W), .ITERS(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi, lo} computed with plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  // Called #1 after the start edge; samples once per cycle until done or budget runs out.
  task automatic wait_done(output logic [31:0] h, output logic [31:0] l, output int bc, output bit ok);
    h = '0; l = '0; bc = 0; ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (busy) bc++;
      if (done) begin
        ok = 1'b1; h = hi; l = lo;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Caller must be positioned at a negedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int bc, output bit ok);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(h, l, bc, ok);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  d_op [6] = '{OP_MULTU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] d_a  [6] = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] d_b  [6] = '{32'd6, 32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] d_hi [6] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h64, 32'h0};
    logic [31:0] d_lo [6] = '{32'h2A, 32'hFFFF_FFF1, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] h, l;
    int bc, exp_bc;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_op(d_op[i], d_a[i], d_b[i], h, l, bc, ok);
      exp_bc = op_is_div(d_op[i]) ? DIV_BUSY : MUL_BUSY;
      checks++; if (!ok) begin errors++; $display("FAIL directed%0d_timeout: no done pulse", i); end
      checks++; if (h !== d_hi[i]) begin errors++; $display("FAIL directed%0d_hi: got %h want %h", i, h, d_hi[i]); end
      checks++; if (l !== d_lo[i]) begin errors++; $display("FAIL directed%0d_lo: got %h want %h", i, l, d_lo[i]); end
      checks++; if (bc != exp_bc) begin errors++; $display("FAIL directed%0d_busy_cycles: got %0d want %0d", i, bc, exp_bc); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL directed%0d_done_width: done still %b", i, done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int bc;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      exp = model(o, a, b);
      @(negedge clk);
      run_op(o, a, b, h, l, bc, ok);
      checks++; if (!ok || h !== exp[63:32]) begin errors++; $display("FAIL random%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, a, b, h, exp[63:32]); end
      checks++; if (!ok || l !== exp[31:0]) begin errors++; $display("FAIL random%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, a, b, l, exp[31:0]); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] h0, h, l;
    int bc, extra;
    bit ok;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_data = 32'd9; rt_data = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    h0 = hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_data = 32'h1234_5678; rt_data = 32'd9; mthi = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    checks++; if (hi !== h0) begin errors++; $display("FAIL busy_mthi_ignored: got %h want %h", hi, h0); end
    wait_done(h, l, bc, ok);
    checks++; if (!ok || l !== 32'd2) begin errors++; $display("FAIL busy_start_lo: got %h want 2", l); end
    checks++; if (!ok || h !== 32'd1) begin errors++; $display("FAIL busy_start_hi: got %h want 1", h); end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_no_relatch: busy seen %0d cycles want 0", extra); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h, l;
    int bc;
    bit ok;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_both_hi: got %h want deadbeef", hi); end
    checks++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_both_lo: got %h want deadbeef", lo); end
    @(negedge clk);
    mthi = 1'b1; rs_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++; if (hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL mthi_only_hi: got %h want cafef00d", hi); end
    checks++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_only_lo: got %h want deadbeef", lo); end
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_data = 32'd20; rt_data = 32'd3; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_mtlo_accepted: busy %b want 1", busy); end
    checks++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL start_mtlo_dropped: lo %h want deadbeef", lo); end
    wait_done(h, l, bc, ok);
    checks++; if (!ok || l !== 32'd6 || h !== 32'd2) begin errors++; $display("FAIL start_mtlo_result: got hi=%h lo=%h want hi=2 lo=6", h, l); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int bc;
    bit ok;
    @(negedge clk);
    run_op(OP_MULTU, 32'd11, 32'd13, h, l, bc, ok);
    for (int i = 0; i < 3; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = 32'($urandom_range(1, 1000));
      exp = model(o, a, b);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b%0d_done_overlap: done %b want 1", i, done); end
      run_op(o, a, b, h, l, bc, ok);
      checks++; if (!ok || {h, l} !== exp) begin errors++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h: got %h%h want %h", i, o, a, b, h, l, exp); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] h, l;
    int bc;
    bit ok;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_data = 32'h1234_5678; rt_data = 32'hF00F_0FF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: busy=%b done=%b want 0 0", busy, done); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL midreset_hilo: hi=%h lo=%h want 0 0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(OP_MULTU, 32'd3, 32'd3, h, l, bc, ok);
    checks++; if (!ok || l !== 32'd9 || h !== 32'd0) begin errors++; $display("FAIL midreset_restart: got hi=%h lo=%h want 0 9", h, l); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, plus the architectural HI/LO register pair.
- Sits beside the register file, downstream of the operand-read stage: consumes rs/rt read data and produces HI/LO for the MFHI/MFLO write-back path.
- Asserts busy so the pipeline stalls MFHI, MFLO, MTHI, MTLO and any new mul/div until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITERS, WIDTH, number of shift-add / restoring-divide iterations.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low clears all state.
- start  in  1  request a mul/div; sampled only when busy=0.
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- rs_data  in  WIDTH  multiplicand/dividend; also MTHI/MTLO data.
- rt_data  in  WIDTH  multiplier/divisor.
- mthi  in  1  write rs_data to HI.
- mtlo  in  1  write rs_data to LO.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are committed.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, iteration counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 at edge E1:
  - latch op;
  - latch |rs|, |rt| when signed, raw values when unsigned;
  - latch result-sign flags;
  - busy=1, counter=0, go to CALC.
- CALC: one iteration per edge (E2..E33); counter increments; after the edge where counter reaches ITERS-1, go to FIX.
- FIX, edge E34:
  - apply two's-complement sign fixup;
  - write hi/lo;
  - busy=0, done=1 for exactly one cycle;
  - go to IDLE.
- Latency: start sampled at E1; hi/lo valid and done high after E34; busy high for 33 cycles.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (any sign): lo = all ones, hi = rs_data (as latched, sign-restored).
- DIV overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start while busy=1: ignored; no re-latch.
- mthi/mtlo:
  - honoured only in IDLE, and only when start=0; start has priority and mthi/mtlo are then dropped;
  - ignored while busy;
  - mthi and mtlo together write both registers.
- done and start in the same cycle: new op accepted normally (back-to-back allowed).
- Reset asserted mid-operation: abort immediately to the reset values; the next start after release is accepted.
- hi/lo hold their value across CALC; old values stay readable until E34.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the product combinationally at the start edge and go directly IDLE -> FIX;
  - busy high for 1 cycle; done and hi/lo valid after the 2nd edge;
  - DIV/DIVU unchanged.
- Undefined: all ops use the 34-edge iterative path; no WIDTH x WIDTH multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT / OP_MULTU / OP_DIV / OP_DIVU;
  - FSM state encodings;
  - DIV0_QUOTIENT constant (all ones).
- One natural sub-module, muldiv_step: combinational single iteration; selects shift-add or restore-subtract by a mode bit and returns the next partial remainder/accumulator and quotient bit.

Test Plan:
- MULTU rs=7, rt=6 -> after E34: hi=0x00000000, lo=0x0000002A, done pulses once, busy high exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 9/4, pulse start with other operands and mthi=1 at cycle 5 -> both ignored; final lo=2, hi=1.
- Start MULT, drive reset low at cycle 10 -> immediately busy=0, hi=lo=0, done=0; release and start MULTU 3*3 -> lo=9.
- Idle mthi=1, mtlo=1, rs=0xDEADBEEF -> hi=lo=0xDEADBEEF; start + mtlo together -> start accepted, lo unchanged until done.
